// File: rtl/key_repeat_if.sv
// Key-level inputs from the PS/2 decoder and the step/enter strobes toward game logic.
interface key_repeat_if;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       enter;
    logic       move_pulse;
    logic [1:0] dir;
    logic       held;
    logic       enter_pulse;

    modport master (
        output up, down, left, right, enter,
        input  move_pulse, dir, held, enter_pulse
    );

    modport slave (
        input  up, down, left, right, enter,
        output move_pulse, dir, held, enter_pulse
    );
endinterface

// File: rtl/key_repeat.sv
// Direction-key auto-repeat: immediate step on press, then repeats after an initial delay.
// Enter produces a single rising-edge strobe with no repeat.
module key_repeat #(
    parameter int unsigned DELAY_CYC  = 25000000,
    parameter int unsigned REPEAT_CYC = 10000000
) (
    input logic         clk,
    input logic         rst,
    key_repeat_if.slave kr_if
);

    localparam logic [24:0] DelayLoad  = 25'(DELAY_CYC - 1);
    localparam logic [24:0] RepeatLoad = 25'(REPEAT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

    state_e      state_q;
    logic [24:0] cnt_q;
    logic        move_q;
    logic [1:0]  dir_q;
    logic        held_q;
    logic        enter_prev_q;
    logic        enter_pulse_q;

    logic        sel_valid;
    logic [1:0]  sel_key;

    always_comb begin
        sel_valid = kr_if.up | kr_if.down | kr_if.left | kr_if.right;
        if (kr_if.up) begin
            sel_key = 2'd0;
        end else if (kr_if.down) begin
            sel_key = 2'd1;
        end else if (kr_if.left) begin
            sel_key = 2'd2;
        end else begin
            sel_key = 2'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            move_q        <= 1'b0;
            dir_q         <= 2'd0;
            held_q        <= 1'b0;
            enter_prev_q  <= 1'b0;
            enter_pulse_q <= 1'b0;
        end else begin
            enter_prev_q  <= kr_if.enter;
            enter_pulse_q <= kr_if.enter & ~enter_prev_q;
            // FSM leaves IDLE exactly when some key is selected this cycle
            held_q        <= sel_valid;
            move_q        <= 1'b0;
            unique case (state_q)
                StDelay, StRepeat: begin
                    if (!sel_valid) begin
                        state_q <= StIdle;
                    end else if (sel_key != dir_q) begin
                        state_q <= StDelay;
                        cnt_q   <= DelayLoad;
                        move_q  <= 1'b1;
                        dir_q   <= sel_key;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 25'd1;
                    end else begin
                        state_q <= StRepeat;
                        cnt_q   <= RepeatLoad;
                        move_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    if (sel_valid) begin
                        state_q <= StDelay;
                        cnt_q   <= DelayLoad;
                        move_q  <= 1'b1;
                        dir_q   <= sel_key;
                    end
                end
            endcase
        end
    end

    assign kr_if.move_pulse  = move_q;
    assign kr_if.dir         = dir_q;
    assign kr_if.held        = held_q;
    assign kr_if.enter_pulse = enter_pulse_q;

endmodule

// File: tb/tb_key_repeat.sv
// Directed bench for key_repeat with DELAY_CYC=4, REPEAT_CYC=2.
module tb_key_repeat;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   n_ent;

    key_repeat_if bus ();

    key_repeat #(
        .DELAY_CYC (4),
        .REPEAT_CYC(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .kr_if(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic mp, input logic [1:0] d,
                           input logic h);
        chk({tag, "_mp"}, 32'(bus.move_pulse), 32'(mp));
        chk({tag, "_dir"}, 32'(bus.dir), 32'(d));
        chk({tag, "_held"}, 32'(bus.held), 32'(h));
    endtask

    task automatic chk_all_zero(input string tag);
        chk_out(tag, 1'b0, 2'd0, 1'b0);
        chk({tag, "_ent"}, 32'(bus.enter_pulse), 32'd0);
    endtask

    initial begin
        bus.up = 1'b0; bus.down = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
        bus.enter = 1'b0;

        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick(); tick();
        chk_all_zero("idle");

        // single hold: pulses at relative edges 0,4,6,8,10
        bus.right = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_out($sformatf("hold%0d", i),
                    (i == 0 || i == 4 || i == 6 || i == 8 || i == 10), 2'd3, 1'b1);
        end
        bus.right = 1'b0;
        tick();
        chk_out("hold_rel", 1'b0, 2'd3, 1'b0);

        // release exactly at delay expiry: no second pulse
        bus.left = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("exp%0d", i), (i == 0), 2'd2, 1'b1);
        end
        bus.left = 1'b0;
        tick();
        chk_out("exp_rel", 1'b0, 2'd2, 1'b0);
        tick();
        chk_out("exp_idle", 1'b0, 2'd2, 1'b0);

        // key change restarts the delay with an immediate pulse
        bus.down = 1'b1;
        tick(); chk_out("chg0", 1'b1, 2'd1, 1'b1);
        tick(); chk_out("chg1", 1'b0, 2'd1, 1'b1);
        bus.up = 1'b1;
        tick(); chk_out("chg2", 1'b1, 2'd0, 1'b1);
        tick(); chk_out("chg3", 1'b0, 2'd0, 1'b1);
        tick(); chk_out("chg4", 1'b0, 2'd0, 1'b1);
        tick(); chk_out("chg5", 1'b0, 2'd0, 1'b1);
        tick(); chk_out("chg6", 1'b1, 2'd0, 1'b1);
        bus.up = 1'b0; bus.down = 1'b0;
        tick(); chk_out("chg_rel", 1'b0, 2'd0, 1'b0);

        // priority: down beats left and right; dropping down selects left
        bus.left = 1'b1; bus.right = 1'b1; bus.down = 1'b1;
        tick(); chk_out("pri0", 1'b1, 2'd1, 1'b1);
        tick(); chk_out("pri1", 1'b0, 2'd1, 1'b1);
        bus.down = 1'b0;
        tick(); chk_out("pri2", 1'b1, 2'd2, 1'b1);
        bus.left = 1'b0; bus.right = 1'b0;
        tick(); chk_out("pri_rel", 1'b0, 2'd2, 1'b0);
        tick(); chk_out("dir_keep", 1'b0, 2'd2, 1'b0);

        // enter held 50 cycles gives one strobe, on the first cycle
        bus.enter = 1'b1;
        n_ent = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i == 0) chk("ent_first", 32'(bus.enter_pulse), 32'd1);
            if (bus.enter_pulse) n_ent++;
        end
        chk("ent_count", 32'(n_ent), 32'd1);

        // reset pulse while enter held: outputs clear, one more strobe after release
        rst = 1'b1;
        #1;
        chk_all_zero("ent_rst_async");
        tick(); tick();
        chk_all_zero("ent_rst_hold");
        rst = 1'b0;
        tick(); chk("ent_after_rst", 32'(bus.enter_pulse), 32'd1);
        tick(); chk("ent_after_rst2", 32'(bus.enter_pulse), 32'd0);
        bus.enter = 1'b0;
        tick();

        // reset mid-hold aborts; held key at release counts as a new press
        bus.up = 1'b1;
        tick(); chk_out("rmh0", 1'b1, 2'd0, 1'b1);
        tick(); chk_out("rmh1", 1'b0, 2'd0, 1'b1);
        rst = 1'b1;
        #1;
        chk_all_zero("rmh_async");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all_zero($sformatf("rmh_rst%0d", i));
        end
        rst = 1'b0;
        tick(); chk_out("rmh_new", 1'b1, 2'd0, 1'b1);
        tick(); chk_out("rmh_next", 1'b0, 2'd0, 1'b1);
        bus.up = 1'b0;
        tick(); chk_out("rmh_rel", 1'b0, 2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_repeat.md
KEY_REPEAT -- requirements
Module: key_repeat

Interface
REQ-001 Parameter DELAY_CYC, default 25000000, meaning clk cycles from first move pulse to first auto-repeat pulse (range 1..2^25-1).
REQ-002 Parameter REPEAT_CYC, default 10000000, meaning clk cycles between successive auto-repeat pulses (range 1..2^25-1).
REQ-003 Port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Ports up, down, left, right  input  1 each  key-held levels from the PS/2 decoder, synchronous to clk.
REQ-006 Port enter  input  1  enter-key-held level from the PS/2 decoder, synchronous to clk.
REQ-007 Port move_pulse  output  1  one-cycle step strobe for the game logic.
REQ-008 Port dir  output  2  latched direction: 0 = up, 1 = down, 2 = left, 3 = right.
REQ-009 Port held  output  1  high while any direction key is held (FSM not IDLE).
REQ-010 Port enter_pulse  output  1  one-cycle strobe on the press of enter.

Function
REQ-011 The selected key is the highest-priority asserted direction input, with priority up > down > left > right; if none is asserted, no key is selected.
REQ-012 The FSM has the states IDLE, DELAY, and REPEAT, plus a 25-bit down-counter cnt.
REQ-013 IDLE with a key selected: the FSM goes to DELAY, loads cnt with DELAY_CYC-1, registers move_pulse=1 for the next cycle, and loads dir with the selected key.
REQ-014 DELAY or REPEAT with the same key selected and cnt != 0: decrement cnt; move_pulse=0.
REQ-015 DELAY or REPEAT with the same key selected and cnt == 0: go to REPEAT, load cnt with REPEAT_CYC-1, and emit move_pulse=1.
REQ-016 DELAY or REPEAT with a different key selected: behave as REQ-013 (new dir, immediate pulse, restart DELAY).
REQ-017 DELAY or REPEAT with no key selected: go to IDLE with no pulse, even if cnt == 0 in the same cycle.
REQ-018 Resulting pulse timing for an unbroken hold sampled first at edge n0: pulses are registered at edges n0, n0+DELAY_CYC, n0+DELAY_CYC+REPEAT_CYC, n0+DELAY_CYC+2*REPEAT_CYC, and so on.
REQ-019 Each pulse is visible one cycle after its registering edge, and move_pulse is never high for two consecutive cycles unless a key change forces REQ-016 right after a pulse.
REQ-020 dir holds its last value after release and changes only with a REQ-013/REQ-016 pulse.
REQ-021 held is 1 in DELAY/REPEAT and 0 in IDLE, registered.
REQ-022 enter_pulse is 1 for exactly one cycle after the edge at which enter is sampled 1 while its previous sample was 0; there is no auto-repeat, and it is independent of the direction FSM.
REQ-023 Opposing keys held together (e.g. up+down) resolve by REQ-011 only; there is no cancellation.

Reset
REQ-024 While rst=1: state=IDLE, cnt=0, move_pulse=0, dir=0, held=0, enter_pulse=0, and the enter history register=0.
REQ-025 rst asserted mid-hold aborts the FSM immediately (no pulse).
REQ-026 If a key is still held at rst release, it is treated as a new press on the first sampling edge after release.
REQ-027 An enter held across rst release produces one enter_pulse.

Verification (DELAY_CYC=4, REPEAT_CYC=2)
REQ-028 Scenario "single hold": hold right from edge 10 for 12 cycles -> move_pulse high after edges 10, 14, 16, 18, 20; dir=3; held high during cycles 11..22.
REQ-029 Scenario "release at expiry": hold left for exactly 4 edges (10..13) with release sampled at edge 14 -> a single pulse after edge 10 only; state IDLE; dir stays 2.
REQ-030 Scenario "key change": hold down from edge 10, add up at edge 12 -> pulses after edges 10 (dir=1) and 12 (dir=0), the next pulse after edge 16.
REQ-031 Scenario "priority": assert left+right+down together -> dir=1; drop down -> immediate pulse with dir=2.
REQ-032 Scenario "enter": hold enter for 50 cycles -> exactly one enter_pulse.
REQ-033 Scenario "enter with reset": pulse rst while enter is held -> one more enter_pulse after rst release.
REQ-034 Scenario "reset mid-hold": assert rst at edge 12 during an up hold and release it at edge 15 with up still held -> all outputs 0 during reset, then a pulse after edge 15 with dir=0.
